// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/DMA memory arbiter: FSM states and requester identity.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} arb_owner_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way round-robin winner select between the CPU and DMA ports.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic       cpu_req,
  input  logic       dma_req,
  input  arb_owner_t last,
  output logic       grant_valid,
  output arb_owner_t grant_owner
);

  // On a tie the port that did not win the previous grant goes next.
  always_comb begin
    grant_valid = cpu_req | dma_req;
    grant_owner = OWN_CPU;
    if (cpu_req && dma_req) begin
      grant_owner = (last == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (dma_req) begin
      grant_owner = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes CPU and DMA accesses onto the single unified memory, holding each
// request for MEM_LAT cycles and returning a one-cycle ready pulse to the owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t        state;
  arb_state_t        state_next;
  arb_owner_t        owner;
  arb_owner_t        last;
  arb_owner_t        grant_owner;
  logic              grant_valid;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;

  assign cnt_zero = (cnt == '0);

  mem_arb_rr_pick u_pick (
    .cpu_req     (cpu_req),
    .dma_req     (dma_req),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  if (cnt_zero) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are frozen at grant so the memory sees a stable access even
  // if the requester misbehaves; rdata only moves on a completing read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= OWN_CPU;
      last      <= OWN_DMA;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner   <= grant_owner;
            last    <= grant_owner;
            we_q    <= (grant_owner == OWN_CPU) ? cpu_we : dma_we;
            addr_q  <= (grant_owner == OWN_CPU) ? cpu_addr : dma_addr;
            wdata_q <= (grant_owner == OWN_CPU) ? cpu_wdata : dma_wdata;
            cnt     <= CNT_LOAD;
          end
        end
        ACCESS: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else if (!we_q) begin
            if (owner == OWN_CPU) cpu_rdata <= mem_rdata;
            else                  dma_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign cpu_ready = (state == RESP) && (owner == OWN_CPU);
  assign dma_ready = (state == RESP) && (owner == OWN_DMA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level round-robin model with its own memory image.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, cpu_ready, dma_req, dma_we, dma_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dma_addr, dma_wdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        l1_cpu_req, l1_cpu_we, l1_cpu_ready, l1_dma_req, l1_dma_we, l1_dma_ready;
  logic [31:0] l1_cpu_addr, l1_cpu_wdata, l1_cpu_rdata, l1_dma_addr, l1_dma_wdata, l1_dma_rdata;
  logic        l1_mem_en, l1_mem_we;
  logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

  logic [31:0] mem  [64] = '{default: 32'h0};
  logic [31:0] mem1 [64] = '{default: 32'h0};
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_data = 32'h0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .cpu_req(l1_cpu_req), .cpu_we(l1_cpu_we), .cpu_addr(l1_cpu_addr), .cpu_wdata(l1_cpu_wdata),
    .cpu_rdata(l1_cpu_rdata), .cpu_ready(l1_cpu_ready),
    .dma_req(l1_dma_req), .dma_we(l1_dma_we), .dma_addr(l1_dma_addr), .dma_wdata(l1_dma_wdata),
    .dma_rdata(l1_dma_rdata), .dma_ready(l1_dma_ready),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata)
  );

  // Behavioural memories: read data follows the presented address, writes land at the edge.
  assign mem_rdata    = mem[mem_addr[7:2]];
  assign l1_mem_rdata = mem1[l1_mem_addr[7:2]];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx]  <= pre_data;
      mem1[pre_idx] <= pre_data;
    end else begin
      if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      if (l1_mem_en && l1_mem_we) mem1[l1_mem_addr[7:2]] <= l1_mem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    l1_cpu_req = 0; l1_cpu_we = 0; l1_cpu_addr = 0; l1_cpu_wdata = 0;
    l1_dma_req = 0; l1_dma_we = 0; l1_dma_addr = 0; l1_dma_wdata = 0;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] d);
    pre_idx = idx; pre_data = d; pre_we = 1'b1;
    step();
    pre_we = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({cpu_rdata, cpu_ready, dma_rdata, dma_ready, mem_en, mem_we, mem_addr, mem_wdata} !== 132'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {cpu_rdata, cpu_ready, dma_rdata, dma_ready, mem_en, mem_we, mem_addr, mem_wdata});
    end
    checks++;
    if ({l1_cpu_rdata, l1_cpu_ready, l1_dma_rdata, l1_dma_ready, l1_mem_en, l1_mem_we, l1_mem_addr, l1_mem_wdata} !== 132'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_lat1: got %h expected 0",
               {l1_cpu_rdata, l1_cpu_ready, l1_dma_rdata, l1_dma_ready, l1_mem_en, l1_mem_we, l1_mem_addr, l1_mem_wdata});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_cpu_read();
    preload(6'd4, 32'hDEADBEEF);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    for (int c = 1; c <= 4; c++) begin
      logic en;
      step();
      en = (c >= 1 && c <= LAT);
      checks++;
      if ({mem_en, mem_we, mem_addr} !== {en, 1'b0, en ? 32'h10 : 32'h0}) begin
        errors++;
        $display("[TB] FAIL cpu_read_mem c%0d: got %h expected %h", c, {mem_en, mem_we, mem_addr},
                 {en, 1'b0, en ? 32'h10 : 32'h0});
      end
      checks++;
      if ({cpu_ready, dma_ready} !== {c == 3, 1'b0}) begin
        errors++;
        $display("[TB] FAIL cpu_read_ready c%0d: got %b expected %b", c, {cpu_ready, dma_ready}, {c == 3, 1'b0});
      end
      if (c >= 3) begin
        checks++;
        if (cpu_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("[TB] FAIL cpu_read_rdata c%0d: got %h expected deadbeef", c, cpu_rdata);
        end
      end
      if (c == 3) cpu_req = 0;
    end
  endtask

  task automatic test_dma_write();
    dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h1234;
    for (int c = 1; c <= 4; c++) begin
      logic en;
      step();
      en = (c >= 1 && c <= LAT);
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== (en ? {2'b11, 32'h40, 32'h1234} : 66'h0)) begin
        errors++;
        $display("[TB] FAIL dma_write_mem c%0d: got %h expected %h", c, {mem_en, mem_we, mem_addr, mem_wdata},
                 en ? {2'b11, 32'h40, 32'h1234} : 66'h0);
      end
      checks++;
      if ({cpu_ready, dma_ready, dma_rdata} !== {1'b0, c == 3, 32'h0}) begin
        errors++;
        $display("[TB] FAIL dma_write_ready c%0d: got %h expected %h", c, {cpu_ready, dma_ready, dma_rdata},
                 {1'b0, c == 3, 32'h0});
      end
      if (c == 3) begin dma_req = 0; dma_we = 0; end
    end
  endtask

  // Both ports held high from reset: CPU, DMA, CPU, DMA every MEM_LAT+2 cycles.
  task automatic test_tie_order();
    logic [31:0] v_cpu, v_dma;
    v_cpu = $urandom; v_dma = $urandom;
    preload(6'd8, v_cpu);
    preload(6'd9, v_dma);
    pulse_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    dma_req = 1; dma_we = 0; dma_addr = 32'h24;
    for (int c = 1; c <= 16; c++) begin
      logic en, cpu_turn;
      step();
      en = ((c % 4) == 1) || ((c % 4) == 2);
      cpu_turn = ((c / 4) % 2) == 0;
      checks++;
      if ({cpu_ready, dma_ready} !== {c == 3 || c == 11, c == 7 || c == 15}) begin
        errors++;
        $display("[TB] FAIL tie_ready c%0d: got %b expected %b", c, {cpu_ready, dma_ready},
                 {c == 3 || c == 11, c == 7 || c == 15});
      end
      checks++;
      if ({mem_en, mem_addr} !== (en ? {1'b1, cpu_turn ? 32'h20 : 32'h24} : 33'h0)) begin
        errors++;
        $display("[TB] FAIL tie_mem c%0d: got %h expected %h", c, {mem_en, mem_addr},
                 en ? {1'b1, cpu_turn ? 32'h20 : 32'h24} : 33'h0);
      end
      if (c == 3 || c == 11) begin
        checks++;
        if (cpu_rdata !== v_cpu) begin
          errors++;
          $display("[TB] FAIL tie_cpu_rdata c%0d: got %h expected %h", c, cpu_rdata, v_cpu);
        end
      end
      if (c == 7 || c == 15) begin
        checks++;
        if (dma_rdata !== v_dma) begin
          errors++;
          $display("[TB] FAIL tie_dma_rdata c%0d: got %h expected %h", c, dma_rdata, v_dma);
        end
      end
      if (c == 15) begin cpu_req = 0; dma_req = 0; end
    end
  endtask

  task automatic test_back_to_back();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
    for (int c = 1; c <= 8; c++) begin
      logic en;
      step();
      en = (c == 1) || (c == 2) || (c == 5) || (c == 6);
      checks++;
      if ({mem_en, cpu_ready, dma_ready} !== {en, c == 3 || c == 7, 1'b0}) begin
        errors++;
        $display("[TB] FAIL back_to_back c%0d: got %b expected %b", c, {mem_en, cpu_ready, dma_ready},
                 {en, c == 3 || c == 7, 1'b0});
      end
      if (c == 7) cpu_req = 0;
    end
  endtask

  task automatic test_reset_abort();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h38; cpu_wdata = $urandom;
    for (int c = 1; c <= 2; c++) begin
      step();
      checks++;
      if ({mem_en, mem_we} !== 2'b11) begin
        errors++;
        $display("[TB] FAIL abort_access c%0d: got %b expected 11", c, {mem_en, mem_we});
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_we, cpu_ready} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_async: got %b expected 000", {mem_en, mem_we, cpu_ready});
    end
    cpu_req = 0; cpu_we = 0;
    step();
    step();
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if ({mem_en, cpu_ready, dma_ready} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL abort_quiet c%0d: got %b expected 000", c, {mem_en, cpu_ready, dma_ready});
      end
    end
    cpu_req = 1; cpu_addr = 32'h20;
    dma_req = 1; dma_addr = 32'h24;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if ({cpu_ready, dma_ready} !== {c == 3, 1'b0}) begin
        errors++;
        $display("[TB] FAIL abort_tie_ready c%0d: got %b expected %b", c, {cpu_ready, dma_ready}, {c == 3, 1'b0});
      end
      if (c == 1) begin
        checks++;
        if (mem_addr !== 32'h20) begin
          errors++;
          $display("[TB] FAIL abort_tie_addr: got %h expected 00000020", mem_addr);
        end
      end
      if (c == 3) begin cpu_req = 0; dma_req = 0; end
    end
  endtask

  task automatic test_lat1();
    preload(6'd10, 32'hA5A5A5A5);
    l1_dma_req = 1; l1_dma_we = 0; l1_dma_addr = 32'h28;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if ({l1_mem_en, l1_mem_we, l1_mem_addr, l1_mem_wdata} !== ((c == 1) ? {2'b10, 32'h28, 32'h0} : 66'h0)) begin
        errors++;
        $display("[TB] FAIL lat1_mem c%0d: got %h", c, {l1_mem_en, l1_mem_we, l1_mem_addr, l1_mem_wdata});
      end
      checks++;
      if ({l1_cpu_ready, l1_dma_ready, l1_cpu_rdata} !== {1'b0, c == 2, 32'h0}) begin
        errors++;
        $display("[TB] FAIL lat1_ready c%0d: got %h expected %h", c, {l1_cpu_ready, l1_dma_ready, l1_cpu_rdata},
                 {1'b0, c == 2, 32'h0});
      end
      if (c >= 2) begin
        checks++;
        if (l1_dma_rdata !== 32'hA5A5A5A5) begin
          errors++;
          $display("[TB] FAIL lat1_rdata c%0d: got %h expected a5a5a5a5", c, l1_dma_rdata);
        end
      end
      if (c == 2) l1_dma_req = 0;
    end
  endtask

  // Random requesters obeying the hold-until-ready rule; the model tracks which
  // port is served when, and what each read must return, from a private memory image.
  task automatic test_random();
    bit          pend [2];
    logic        pwe [2];
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [31:0] exp_rdata [2];
    logic [31:0] ref_mem [64];
    bit          busy;
    int          g, own, mlast;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; pwe[p] = 0; paddr[p] = 0; pwdata[p] = 0; exp_rdata[p] = 0;
    end
    busy = 0; g = 0; own = 0; mlast = 1;
    idle_inputs();
    pulse_reset();
    for (int m = 1; m <= 800; m++) begin
      logic        acc, rdy;
      logic [65:0] exp_mem;
      step();
      if (busy && m == g + LAT + 2) busy = 0;
      acc = busy && (m >= g + 1) && (m <= g + LAT);
      rdy = busy && (m == g + LAT + 1);
      if (rdy) begin
        if (pwe[own]) ref_mem[paddr[own][7:2]] = pwdata[own];
        else          exp_rdata[own] = ref_mem[paddr[own][7:2]];
        pend[own] = 0;
      end
      exp_mem = acc ? {1'b1, pwe[own], paddr[own], pwdata[own]} : 66'h0;
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== exp_mem) begin
        errors++;
        $display("[TB] FAIL rand_mem cycle %0d: got %h expected %h", m, {mem_en, mem_we, mem_addr, mem_wdata}, exp_mem);
      end
      checks++;
      if ({cpu_ready, dma_ready} !== {rdy && own == 0, rdy && own == 1}) begin
        errors++;
        $display("[TB] FAIL rand_ready cycle %0d: got %b expected %b", m, {cpu_ready, dma_ready},
                 {rdy && own == 0, rdy && own == 1});
      end
      checks++;
      if ({cpu_rdata, dma_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
        errors++;
        $display("[TB] FAIL rand_rdata cycle %0d: got %h expected %h", m, {cpu_rdata, dma_rdata},
                 {exp_rdata[0], exp_rdata[1]});
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p]   = 1;
          pwe[p]    = $urandom_range(0, 1) == 1;
          paddr[p]  = 32'h80 + 32'($urandom_range(0, 31)) * 4;
          pwdata[p] = $urandom;
        end
      end
      cpu_req = pend[0]; cpu_we = pwe[0]; cpu_addr = paddr[0]; cpu_wdata = pwdata[0];
      dma_req = pend[1]; dma_we = pwe[1]; dma_addr = paddr[1]; dma_wdata = pwdata[1];
      if (!busy && (pend[0] || pend[1])) begin
        own   = (pend[0] && pend[1]) ? (1 - mlast) : (pend[0] ? 0 : 1);
        mlast = own;
        g     = m;
        busy  = 1;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_tie_order();
    test_back_to_back();
    test_reset_abort();
    test_lat1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory of the multicycle CPU between the CPU memory port and a DMA/loader port. It serializes accesses with round-robin fairness and holds the memory request stable for a fixed access latency. It returns read data and a one-cycle `ready` pulse to the granted requester. The CPU controller stalls its fetch/load/store state until `cpu_ready` is seen.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MEM_LAT`, default 2: memory access cycles. Must be at least 1.

- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `cpu_req`, in, 1: CPU requests an access.
- `cpu_we`, in, 1: CPU access is a write.
- `cpu_addr`, in, ADDR_W: CPU address.
- `cpu_wdata`, in, DATA_W: CPU write data.
- `cpu_rdata`, out, DATA_W: last CPU read result, registered.
- `cpu_ready`, out, 1: one-cycle completion pulse to the CPU.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ready`: same as the CPU set, for the DMA port.
- `mem_en`, out, 1: memory access strobe.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, ADDR_W: memory address.
- `mem_wdata`, out, DATA_W: memory write data.
- `mem_rdata`, in, DATA_W: memory read data, valid in the last access cycle.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE
  - No request: stay in IDLE.
  - Any `req` high: choose the winner. Latch owner, `we`, `addr` and `wdata` into internal registers. Load the counter with MEM_LAT-1. Go to ACCESS.
- ACCESS
  - Drive `mem_en=1`.
  - Drive `mem_we` = latched `we`, `mem_addr` = latched `addr`, `mem_wdata` = latched `wdata`.
  - Counter not zero: decrement it.
  - Counter zero: if the access is a read, capture `mem_rdata` into the owner's `rdata` register. Go to RESP.
- RESP
  - Owner's `ready` = 1 for this single cycle.
  - `req` inputs are ignored.
  - Always go to IDLE next.
- Arbitration is 2-way round robin using a `last` register, which updates when the grant is made.
  - Only one requester: it wins.
  - Both requesting: the owner not equal to `last` wins.
  - `last` resets to DMA, so the CPU wins the first tie.
- Requester rule:
  - Hold `req`, `we`, `addr` and `wdata` stable from assertion until its `ready` cycle.
  - At the edge ending the `ready` cycle, either drop `req` or keep it high to request a new transaction, which is sampled in IDLE.
- `rdata` registers:
  - Change only on a completing read by that owner.
  - Writes leave them unchanged.
- Outputs `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are 0 outside ACCESS.
- Reset
  - All outputs 0, state IDLE, `last`=DMA, counter 0, both `rdata` registers 0.
  - Reset in ACCESS aborts the transaction immediately (asynchronous). `mem_en` and `mem_we` drop with no further memory cycles. No `ready` pulse is issued for the aborted access.

## Timing
- Request high in IDLE in cycle 0: ACCESS in cycles 1..MEM_LAT, `ready` in cycle MEM_LAT+1.
- Cycle MEM_LAT+2 is IDLE.
- Minimum issue interval per transaction is MEM_LAT+2 cycles. Back-to-back alternating grants have no extra bubble.
- `rdata` is valid in the `ready` cycle and holds afterwards.
- All outputs are registered or decoded from state and latched registers. There is no combinational path from `req` or `mem_rdata` to any output.
- Counter width is $clog2(MEM_LAT). Use 1 bit when MEM_LAT=1.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t` enum {IDLE, ACCESS, RESP};
  - `arb_owner_t` enum {OWN_CPU, OWN_DMA}.
- Sub-module `mem_arb_rr_pick` is the combinational winner select from `cpu_req`, `dma_req` and `last`. It outputs `grant_valid` and `grant_owner`.
- The top module holds the FSM, latched request, counter, `last` and `rdata` registers, and the output muxing.

## Test plan
Scenarios use MEM_LAT=2 unless stated.
- CPU read alone: `cpu_req=1`, `addr=0x10`, memory returns `0xDEADBEEF` → `mem_en` high in cycles 1-2, `cpu_ready` in cycle 3, `cpu_rdata=0xDEADBEEF`, `dma_ready` never asserted.
- DMA write: `dma_we=1`, `addr=0x40`, `wdata=0x1234` → `mem_we=1`, `mem_addr=0x40`, `mem_wdata=0x1234` in cycles 1-2. `dma_ready` in cycle 3. `dma_rdata` is unchanged (0).
- Simultaneous requests after reset, both held high → grant order CPU, DMA, CPU, DMA. `ready` pulses in cycles 3, 7, 11, 15.
- CPU keeps `req` high after `ready` while DMA is idle → CPU granted again in the IDLE cycle following RESP, next `cpu_ready` 4 cycles later.
- Reset asserted in the second ACCESS cycle of a CPU write → `mem_en` and `mem_we` 0 immediately, no `cpu_ready`. After release, `last`=DMA, so a tie goes to CPU.
- MEM_LAT=1: DMA read `0xA5A5A5A5` → single ACCESS cycle, `dma_ready` in cycle 2, `dma_rdata=0xA5A5A5A5`.
